// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between instruction fetch and
// the MEM-stage data requester. Requests pass through combinationally. A lock
// holds the grant while a request waits for addr_ok. A small owner FIFO steers
// each data_ok/rdata back to the requester that issued it.
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {LK_FREE, LK_INST, LK_DATA} lock_e;

  lock_e          r_lock_st;
  lock_e          w_lock_nx;
  logic [AW:0]    r_count;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [DEPTH-1:0] r_owner;   // 1 = data, 0 = inst

  logic w_sel;
  logic w_sel_req;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Owner select: a held lock wins, otherwise data has fixed priority
  always_comb begin
    w_sel = data_req;
    case (r_lock_st)
      LK_INST: w_sel = 1'b0;
      LK_DATA: w_sel = 1'b1;
      default: w_sel = data_req;
    endcase
  end

  // Full gate uses the registered count, so a pop frees a slot next cycle
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_sel_req = w_sel ? data_req : inst_req;
  assign w_push    = mem_req & mem_addr_ok;
  // A data_ok with nothing outstanding is a protocol error and is dropped
  assign w_pop     = mem_data_ok & (r_count != '0);
  assign w_head    = r_owner[r_rptr];

  assign mem_req   = w_sel_req & ~w_full;
  assign mem_wr    = w_sel & data_wr;
  assign mem_size  = w_sel ? data_size  : inst_size;
  assign mem_wstrb = w_sel ? data_wstrb : 4'b0;
  assign mem_addr  = w_sel ? data_addr  : inst_addr;
  assign mem_wdata = w_sel ? data_wdata : 32'b0;

  assign inst_addr_ok = mem_addr_ok & mem_req & ~w_sel;
  assign data_addr_ok = mem_addr_ok & mem_req &  w_sel;
  assign inst_data_ok = w_pop & ~w_head;
  assign data_data_ok = w_pop &  w_head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Lock state register
  always_ff @(posedge clk) begin
    if (!resetn) r_lock_st <= LK_FREE;
    else         r_lock_st <= w_lock_nx;
  end

  // Lock next-state: take it on a stalled request, drop it on accept or when
  // the owner withdraws. Gated-by-full cycles neither set nor clear it.
  always_comb begin
    w_lock_nx = r_lock_st;
    case (r_lock_st)
      LK_FREE: begin
        if (mem_req && !mem_addr_ok) w_lock_nx = w_sel ? LK_DATA : LK_INST;
      end
      default: begin
        if (!w_sel_req || (mem_req && mem_addr_ok)) w_lock_nx = LK_FREE;
      end
    endcase
  end

  // Ordering FIFO: record owner on accept, retire head on response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_owner <= '0;
    end else begin
      if (w_push) begin
        r_owner[r_wptr] <= w_sel;
        r_wptr          <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that shares one SRAM-like memory port between the instruction-fetch requester and the data (MEM-stage) requester. It forwards requests combinationally, holds the grant stable while a request waits for `addr_ok`, and tracks up to `DEPTH` outstanding transactions in an ordering FIFO so each `data_ok`/`rdata` returns to the requester that issued it. It sits between the CPU core and the AXI bridge or memory.

## Interface
- `DEPTH`, 4 — maximum outstanding accepted transactions; power of 2, ≥2
- `clk`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `inst_req`  in  1  instruction read request
- `inst_addr`  in  32  instruction address
- `inst_size`  in  2  bytes = 2^size
- `inst_addr_ok`  out  1  instruction request accepted this cycle
- `inst_data_ok`  out  1  instruction response valid this cycle
- `inst_rdata`  out  32  instruction read data
- `data_req`  in  1  data request
- `data_wr`  in  1  1 = write, 0 = read
- `data_size`  in  2  bytes = 2^size
- `data_wstrb`  in  4  write byte enables
- `data_addr`  in  32  data address
- `data_wdata`  in  32  write data
- `data_addr_ok`  out  1  data request accepted this cycle
- `data_data_ok`  out  1  data response (read data or write ack) valid
- `data_rdata`  out  32  data read data
- `mem_req`  out  1  shared-port request
- `mem_wr`  out  1  shared-port write flag
- `mem_size`  out  2  shared-port size
- `mem_wstrb`  out  4  shared-port byte enables
- `mem_addr`  out  32  shared-port address
- `mem_wdata`  out  32  shared-port write data
- `mem_addr_ok`  in  1  memory accepted the request
- `mem_data_ok`  in  1  memory response valid
- `mem_rdata`  in  32  memory read data

## Operation
- Owner select: `sel` is 1 for data and 0 for instruction.
  - When unlocked, `sel = data_req`. Data has fixed priority because it is older in program order.
  - When locked, `sel = lock_owner`.
- Lock:
  - Set when `mem_req & ~mem_addr_ok`. Record `lock_owner = sel`.
  - Clear on `mem_addr_ok`, or when the locked owner deasserts its req.
  - While locked, the other requester cannot steal the port.
- `full = (count == DEPTH)`.
- `mem_req = (sel ? data_req : inst_req) & ~full`.
- `mem_addr/size/wstrb/wdata/wr` are muxed by `sel`. On the instruction path: `wr = 0`, `wstrb = 0`, `wdata = 0`.
- `inst_addr_ok = mem_addr_ok & mem_req & ~sel`.
- `data_addr_ok = mem_addr_ok & mem_req & sel`.
- Ordering FIFO: `DEPTH` entries, 1 bit each (owner).
  - Push `sel` on `mem_req & mem_addr_ok`.
  - Pop on `mem_data_ok`.
  - Head owner routes the response: `inst_data_ok = mem_data_ok & ~head`, `data_data_ok = mem_data_ok & head`.
  - `rdata` is driven to both requesters from `mem_rdata`.
- Writes occupy a FIFO entry and receive `data_data_ok` like reads.
- `count` is a `log2(DEPTH)+1`-bit counter; read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.

## Timing
- All request and response paths are combinational, with zero added latency. `data_ok` is asserted in the same cycle as `mem_data_ok`.
- Reset: pointers, `count`, and lock all go to 0. With requests idle, every output is 0 (`mem_req`, all `addr_ok`, all `data_ok`).
- Push and pop in the same cycle: both take effect and `count` is unchanged. This is legal even when full, but no push can occur while full because `mem_req` is gated.
- Full: `mem_req` and both `addr_ok` outputs are 0 until a pop.
  - Pop and the new acceptance can occur in the same cycle only from the next cycle's count. The full gate uses the registered `count`.
- `mem_data_ok` while empty is a protocol error: ignore it, assert no `data_ok`, and keep `count` at 0.
- Reset mid-operation discards all outstanding entries. Responses still in flight afterward are treated per the empty rule.
- Lock survives `full`: the owner keeps the lock even while `mem_req` is gated.

## Test plan
- Both `req` high, `mem_addr_ok` = 1 every cycle:
  - `data_addr_ok` is granted every cycle and `inst_addr_ok` stays 0.
  - After `data_req` drops, `inst_addr_ok` = 1 the next cycle.
- `inst_req` only, `mem_addr_ok` held 0 for 3 cycles, `data_req` rises in cycle 1:
  - `mem_addr` stays the instruction address until `addr_ok`.
  - The first accept goes to inst and the FIFO pushes 0.
- Interleave I, D, I, D accepts, then 4 `mem_data_ok` pulses with rdata 0x11..0x44:
  - `inst_data_ok` fires with 0x11 and 0x33.
  - `data_data_ok` fires with 0x22 and 0x44.
- `DEPTH`=4, 4 accepts with no responses:
  - `mem_req` = 0 and both `addr_ok` = 0 while full.
  - One `mem_data_ok` reopens the port the next cycle.
- Simultaneous accept and `mem_data_ok` at `count` = 2: `count` stays 2 and the head routes correctly.
- `resetn` low with 3 outstanding, then a stray `mem_data_ok` after reset: no `data_ok` is asserted and `count` = 0.
